// File: rtl/instr_fetch.sv
// Instruction fetch stage: req/ack fetch into an IR held for decode.
// Optional accepted-instruction counter enabled by defining FETCH_CNT_EN.
module instr_fetch #(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   output logic               o_mem_req,
   output logic [ADDR_W-1:0]  o_mem_addr,
   input  logic [INSTR_W-1:0] i_mem_rdata,
   input  logic               i_mem_ack,
   output logic               o_ir_valid,
   input  logic               i_ir_ready,
   output logic [INSTR_W-1:0] o_instr,
   output logic [5:0]         o_opcode,
   output logic [ADDR_W-1:0]  o_ir_pc,
   input  logic               i_redirect_valid,
`ifdef FETCH_CNT_EN
   input  logic [ADDR_W-1:0]  i_redirect_pc,
   output logic [15:0]        o_fetch_count
`else
   input  logic [ADDR_W-1:0]  i_redirect_pc
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ADDR_W-1:0]    r_pc;
   logic [ADDR_W-1:0]    w_pc_nxt;
   logic [INSTR_W-1:0]   r_instr;
   logic [INSTR_W-1:0]   w_instr_nxt;
   logic [ADDR_W-1:0]    r_ir_pc;
   logic [ADDR_W-1:0]    w_ir_pc_nxt;
   logic                 r_ir_valid;
   logic                 w_ir_valid_nxt;
   logic                 w_accept;

   // Decode hands off the held word; a redirect in the same cycle wins.
   assign w_accept = (r_state == S_HOLD) && i_ir_ready && !i_redirect_valid;

   // State, PC and instruction register update.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_instr    <= '0;
         r_ir_pc    <= '0;
         r_ir_valid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_instr    <= w_instr_nxt;
         r_ir_pc    <= w_ir_pc_nxt;
         r_ir_valid <= w_ir_valid_nxt;
      end
   end

   // Next-state logic; redirect outranks ack and ready outside S_IDLE.
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_instr_nxt    = r_instr;
      w_ir_pc_nxt    = r_ir_pc;
      w_ir_valid_nxt = r_ir_valid;
      unique case (r_state)
         S_IDLE: begin
            w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (i_redirect_valid) begin
               w_pc_nxt       = i_redirect_pc;
               w_ir_valid_nxt = 1'b0;
            end else if (i_mem_ack) begin
               w_instr_nxt    = i_mem_rdata;
               w_ir_pc_nxt    = r_pc;
               w_ir_valid_nxt = 1'b1;
               w_state_nxt    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (i_redirect_valid) begin
               w_pc_nxt       = i_redirect_pc;
               w_ir_valid_nxt = 1'b0;
               w_state_nxt    = S_REQ;
            end else if (w_accept) begin
               w_pc_nxt       = r_pc + ADDR_W'(1);
               w_ir_valid_nxt = 1'b0;
               w_state_nxt    = S_REQ;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_mem_req  = (r_state == S_REQ);
   assign o_mem_addr = r_pc;
   assign o_ir_valid = r_ir_valid;
   assign o_instr    = r_instr;
   assign o_opcode   = {2'b00, r_instr[INSTR_W-1 -: 4]};
   assign o_ir_pc    = r_ir_pc;

`ifdef FETCH_CNT_EN
   logic [15:0] r_fetch_count;

   // Count accepted instructions, saturating at all-ones.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fetch_count <= '0;
      end else if (w_accept && (r_fetch_count != 16'hFFFF)) begin
         r_fetch_count <= r_fetch_count + 16'd1;
      end
   end

   assign o_fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: per-cycle vector table plus async reset check.
// Counter checks are active when FETCH_CNT_EN is defined.
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        ir_valid;
   logic        ir_ready;
   logic [15:0] instr;
   logic [5:0]  opcode;
   logic [7:0]  ir_pc;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic [15:0] fetch_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rst;
      logic        ack;
      logic [15:0] rdata;
      logic        ready;
      logic        redir;
      logic [7:0]  rpc;
      logic        e_req;
      logic [7:0]  e_addr;
      logic        e_valid;
      logic [15:0] e_instr;
      logic [5:0]  e_op;
      logic [7:0]  e_irpc;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   instr_fetch #(
      .ADDR_W  (8),
      .INSTR_W (16),
      .RESET_PC(8'h00)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .o_mem_req       (mem_req),
      .o_mem_addr      (mem_addr),
      .i_mem_rdata     (mem_rdata),
      .i_mem_ack       (mem_ack),
      .o_ir_valid      (ir_valid),
      .i_ir_ready      (ir_ready),
      .o_instr         (instr),
      .o_opcode        (opcode),
      .o_ir_pc         (ir_pc),
      .i_redirect_valid(redirect_valid),
`ifdef FETCH_CNT_EN
      .i_redirect_pc   (redirect_pc),
      .o_fetch_count   (fetch_count)
`else
      .i_redirect_pc   (redirect_pc)
`endif
   );

`ifndef FETCH_CNT_EN
   assign fetch_count = 16'h0000;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int step,
                      input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h",
                  name, step, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic a, input logic [15:0] d,
                      input logic rdy, input logic rv, input logic [7:0] rp,
                      input logic eq, input logic [7:0] ea,
                      input logic ev, input logic [15:0] ei,
                      input logic [7:0] ep, input logic [15:0] ec);
      vec_t v;
      v.rst = r; v.ack = a; v.rdata = d; v.ready = rdy;
      v.redir = rv; v.rpc = rp;
      v.e_req = eq; v.e_addr = ea; v.e_valid = ev;
      v.e_instr = ei; v.e_op = {2'b00, ei[15:12]};
      v.e_irpc = ep; v.e_cnt = ec;
      vecs.push_back(v);
   endtask

   initial begin
      rst = 1'b1;
      mem_ack = 1'b0;
      mem_rdata = '0;
      ir_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;

      //   rst ack rdata    rdy rv rpc    req addr   vld instr    irpc   cnt
      add(1, 0, 16'h0000, 0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, 0); // 0 reset
      add(0, 0, 16'h0000, 0, 0, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h00, 0); // 1 idle->req
      add(0, 1, 16'h0123, 1, 0, 8'h00, 0, 8'h00, 1, 16'h0123, 8'h00, 0); // 2 ack
      add(0, 0, 16'h0000, 1, 0, 8'h00, 1, 8'h01, 0, 16'h0123, 8'h00, 1); // 3 accept
      add(0, 1, 16'hF005, 0, 0, 8'h00, 0, 8'h01, 1, 16'hF005, 8'h01, 1); // 4 ack
      for (int i = 0; i < 5; i++)
         add(0, 0, 16'h0000, 0, 0, 8'h00, 0, 8'h01, 1, 16'hF005, 8'h01, 1); // 5-9 stall
      add(0, 0, 16'h0000, 1, 0, 8'h00, 1, 8'h02, 0, 16'hF005, 8'h01, 2); // 10 accept
      add(0, 0, 16'h0000, 1, 0, 8'h00, 1, 8'h02, 0, 16'hF005, 8'h01, 2); // 11 wait ack
      add(0, 1, 16'h3ABC, 0, 0, 8'h00, 0, 8'h02, 1, 16'h3ABC, 8'h02, 2); // 12 late ack
      add(0, 0, 16'h0000, 1, 1, 8'h40, 1, 8'h40, 0, 16'h3ABC, 8'h02, 2); // 13 redir hold
      add(0, 1, 16'hE012, 0, 0, 8'h00, 0, 8'h40, 1, 16'hE012, 8'h40, 2); // 14 ack 0x40
      add(0, 0, 16'h0000, 1, 0, 8'h00, 1, 8'h41, 0, 16'hE012, 8'h40, 3); // 15 accept
      add(0, 1, 16'h1234, 0, 1, 8'hFF, 1, 8'hFF, 0, 16'hE012, 8'h40, 3); // 16 redir+ack
      add(0, 1, 16'h7777, 0, 0, 8'h00, 0, 8'hFF, 1, 16'h7777, 8'hFF, 3); // 17 ack 0xFF
      add(0, 0, 16'h0000, 1, 0, 8'h00, 1, 8'h00, 0, 16'h7777, 8'hFF, 4); // 18 wrap
      add(0, 0, 16'h0000, 0, 1, 8'h10, 1, 8'h10, 0, 16'h7777, 8'hFF, 4); // 19 redir req
      add(1, 1, 16'h5555, 1, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00, 0); // 20 reset
      add(0, 0, 16'h0000, 0, 1, 8'h55, 1, 8'h00, 0, 16'h0000, 8'h00, 0); // 21 idle redir

      foreach (vecs[i]) begin
         @(negedge clk);
         rst            = vecs[i].rst;
         mem_ack        = vecs[i].ack;
         mem_rdata      = vecs[i].rdata;
         ir_ready       = vecs[i].ready;
         redirect_valid = vecs[i].redir;
         redirect_pc    = vecs[i].rpc;
         @(posedge clk);
         #1;
         chk("mem_req",  i, 32'(mem_req),  32'(vecs[i].e_req));
         chk("mem_addr", i, 32'(mem_addr), 32'(vecs[i].e_addr));
         chk("ir_valid", i, 32'(ir_valid), 32'(vecs[i].e_valid));
         chk("instr",    i, 32'(instr),    32'(vecs[i].e_instr));
         chk("opcode",   i, 32'(opcode),   32'(vecs[i].e_op));
         chk("ir_pc",    i, 32'(ir_pc),    32'(vecs[i].e_irpc));
`ifdef FETCH_CNT_EN
         chk("fetch_count", i, 32'(fetch_count), 32'(vecs[i].e_cnt));
`endif
      end

      // Get a word into the IR, then reset between edges.
      @(negedge clk);
      rst = 1'b0; redirect_valid = 1'b0;
      mem_ack = 1'b1; mem_rdata = 16'hB00B; ir_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_async_valid", 100, 32'(ir_valid), 32'd1);
      chk("pre_async_op",    100, 32'(opcode),   32'h0B);
      @(negedge clk);
      mem_ack = 1'b0;
      rst = 1'b1;
      #1;
      chk("async_valid", 101, 32'(ir_valid), 32'd0);
      chk("async_req",   101, 32'(mem_req),  32'd0);
      chk("async_instr", 101, 32'(instr),    32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_req", 102, 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;
      chk("rel_req",  103, 32'(mem_req),  32'd1);
      chk("rel_addr", 103, 32'(mem_addr), 32'd0);

      // Request held while no ack arrives.
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("hold_req",  104, 32'(mem_req),  32'd1);
         chk("hold_addr", 104, 32'(mem_addr), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
